// File: rtl/miriscv_mem_arbiter_if.sv
// Bus bundle between the miriscv fetch/LSU ports, the arbiter and unified memory.
interface miriscv_mem_arbiter_if #(
  parameter int unsigned XLEN = 32
);
  localparam int unsigned BE_W = XLEN / 8;

  // Instruction-fetch port
  logic            instr_req_i;
  logic [XLEN-1:0] instr_addr_i;
  logic            instr_rvalid_o;
  logic [XLEN-1:0] instr_rdata_o;

  // LSU data port
  logic            data_req_i;
  logic            data_we_i;
  logic [BE_W-1:0] data_be_i;
  logic [XLEN-1:0] data_addr_i;
  logic [XLEN-1:0] data_wdata_i;
  logic            data_rvalid_o;
  logic [XLEN-1:0] data_rdata_o;

  // Shared memory bus
  logic            mem_req_o;
  logic            mem_we_o;
  logic [BE_W-1:0] mem_be_o;
  logic [XLEN-1:0] mem_addr_o;
  logic [XLEN-1:0] mem_wdata_o;
  logic            mem_rvalid_i;
  logic [XLEN-1:0] mem_rdata_i;

  // Arbiter side
  modport slave (
    input  instr_req_i, instr_addr_i,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  mem_rvalid_i, mem_rdata_i,
    output instr_rvalid_o, instr_rdata_o,
    output data_rvalid_o, data_rdata_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );

  // Requester/memory side
  modport master (
    output instr_req_i, instr_addr_i,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output mem_rvalid_i, mem_rdata_i,
    input  instr_rvalid_o, instr_rdata_o,
    input  data_rvalid_o, data_rdata_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/miriscv_mem_arbiter.sv
// Two-port (fetch/LSU) arbiter onto one single-port memory bus, one transaction
// outstanding, with a watchdog that aborts responses that never arrive.
module miriscv_mem_arbiter #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     ARB_MODE = 0,
  parameter int unsigned     TIMEOUT  = 255,
  parameter logic [XLEN-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                 clk_i,
  input  logic                 arstn_i,
  miriscv_mem_arbiter_if.slave bus,
  output logic                 timeout_o,
  output logic                 busy_o
);
  localparam int unsigned BE_W  = XLEN / 8;
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY_I = 2'd1,
    S_BUSY_D = 2'd2
  } state_e;

  state_e          r_state;
  logic            r_last_d;
  logic [CNT_W-1:0] r_cnt;
  logic            r_mem_req;
  logic            r_mem_we;
  logic [BE_W-1:0] r_mem_be;
  logic [XLEN-1:0] r_mem_addr;
  logic [XLEN-1:0] r_mem_wdata;

  logic            w_grant_d;
  logic            w_grant_i;
  logic            w_busy;
  logic            w_abort;
  logic            w_done;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [XLEN-1:0] w_rdata;

  // Arbitration among the requests presented while idle
  always_comb begin
    w_grant_d = 1'b0;
    w_grant_i = 1'b0;
    if (bus.data_req_i && bus.instr_req_i) begin
      if (ARB_MODE == 0) begin
        w_grant_d = 1'b1;
      end else begin
        w_grant_d = !r_last_d;
      end
      w_grant_i = !w_grant_d;
    end else begin
      w_grant_d = bus.data_req_i;
      w_grant_i = bus.instr_req_i;
    end
  end

  // Watchdog: counter value including the current silent cycle reaching TIMEOUT aborts
  assign w_busy    = (r_state != S_IDLE);
  assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_abort   = (TIMEOUT != 0) && w_busy && !bus.mem_rvalid_i &&
                     (w_cnt_inc == CNT_W'(TIMEOUT));
  assign w_done    = w_busy && (bus.mem_rvalid_i || w_abort);

  // Response routing back to the current winner; memory response beats the abort
  assign w_rdata            = w_abort ? ERR_DATA : bus.mem_rdata_i;
  assign bus.instr_rvalid_o = (r_state == S_BUSY_I) && w_done;
  assign bus.data_rvalid_o  = (r_state == S_BUSY_D) && w_done;
  assign bus.instr_rdata_o  = w_rdata;
  assign bus.data_rdata_o   = w_rdata;
  assign timeout_o          = w_abort;
  assign busy_o             = w_busy;

  assign bus.mem_req_o   = r_mem_req;
  assign bus.mem_we_o    = r_mem_we;
  assign bus.mem_be_o    = r_mem_be;
  assign bus.mem_addr_o  = r_mem_addr;
  assign bus.mem_wdata_o = r_mem_wdata;

  // Arbiter FSM with registered memory-bus fields
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state     <= S_IDLE;
      r_last_d    <= 1'b0;
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_grant_d || w_grant_i) begin
            r_state     <= w_grant_d ? S_BUSY_D : S_BUSY_I;
            r_last_d    <= w_grant_d;
            r_cnt       <= '0;
            r_mem_req   <= 1'b1;
            r_mem_we    <= w_grant_d & bus.data_we_i;
            r_mem_be    <= w_grant_d ? bus.data_be_i : {BE_W{1'b1}};
            r_mem_addr  <= w_grant_d ? bus.data_addr_i : bus.instr_addr_i;
            r_mem_wdata <= w_grant_d ? bus.data_wdata_i : '0;
          end
        end
        S_BUSY_I, S_BUSY_D: begin
          if (w_done) begin
            r_state   <= S_IDLE;
            r_mem_req <= 1'b0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// Directed bench: a fixed-priority and a round-robin arbiter (both TIMEOUT=4)
// driven by the same requesters, each with its own simple memory responder.
module tb_miriscv_mem_arbiter;
  localparam int unsigned XLEN = 32;
  localparam int unsigned TOUT = 4;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  miriscv_mem_arbiter_if #(.XLEN(XLEN)) bus0 ();
  miriscv_mem_arbiter_if #(.XLEN(XLEN)) bus1 ();

  logic to0, to1, busy0, busy1;

  // Shared requester stimulus
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;

  // Memory responder controls
  int          mem_lat;
  bit          mem_silent;
  logic        mem_stray;
  logic [31:0] mem_rd;
  logic        m0_rvalid, m1_rvalid;
  int          m0_cnt, m1_cnt;

  int n_checks;
  int n_fail;

  assign bus0.instr_req_i  = instr_req;
  assign bus0.instr_addr_i = instr_addr;
  assign bus0.data_req_i   = data_req;
  assign bus0.data_we_i    = data_we;
  assign bus0.data_be_i    = data_be;
  assign bus0.data_addr_i  = data_addr;
  assign bus0.data_wdata_i = data_wdata;
  assign bus0.mem_rvalid_i = m0_rvalid | mem_stray;
  assign bus0.mem_rdata_i  = mem_rd;

  assign bus1.instr_req_i  = instr_req;
  assign bus1.instr_addr_i = instr_addr;
  assign bus1.data_req_i   = data_req;
  assign bus1.data_we_i    = data_we;
  assign bus1.data_be_i    = data_be;
  assign bus1.data_addr_i  = data_addr;
  assign bus1.data_wdata_i = data_wdata;
  assign bus1.mem_rvalid_i = m1_rvalid | mem_stray;
  assign bus1.mem_rdata_i  = mem_rd;

  miriscv_mem_arbiter #(
    .XLEN(XLEN), .ARB_MODE(0), .TIMEOUT(TOUT), .ERR_DATA(32'hDEAD_BEEF)
  ) u_dut_fp (
    .clk_i(clk), .arstn_i(rst_n), .bus(bus0), .timeout_o(to0), .busy_o(busy0)
  );

  miriscv_mem_arbiter #(
    .XLEN(XLEN), .ARB_MODE(1), .TIMEOUT(TOUT), .ERR_DATA(32'hDEAD_BEEF)
  ) u_dut_rr (
    .clk_i(clk), .arstn_i(rst_n), .bus(bus1), .timeout_o(to1), .busy_o(busy1)
  );

  // Memory answers mem_lat cycles after mem_req_o rises
  always @(negedge clk) begin
    if (!rst_n || !bus0.mem_req_o || mem_silent) begin
      m0_rvalid <= 1'b0;
      m0_cnt    <= 0;
    end else if (m0_cnt == mem_lat) begin
      m0_rvalid <= 1'b1;
      m0_cnt    <= 0;
    end else begin
      m0_rvalid <= 1'b0;
      m0_cnt    <= m0_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n || !bus1.mem_req_o || mem_silent) begin
      m1_rvalid <= 1'b0;
      m1_cnt    <= 0;
    end else if (m1_cnt == mem_lat) begin
      m1_rvalid <= 1'b1;
      m1_cnt    <= 0;
    end else begin
      m1_rvalid <= 1'b0;
      m1_cnt    <= m1_cnt + 1;
    end
  end

  // Requesters must hold req until their rvalid
  a_instr_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (instr_req && !bus0.instr_rvalid_o) |=> instr_req)
    else $error("FAIL instr_req_hold: req=0 required 1 before rvalid");
  a_data_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (data_req && !bus0.data_rvalid_o) |=> data_req)
    else $error("FAIL data_req_hold: req=0 required 1 before rvalid");

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to the middle of the next low clock phase
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0;
    instr_req = 1'b0; instr_addr = '0;
    data_req = 1'b0; data_we = 1'b0; data_be = '0; data_addr = '0; data_wdata = '0;
    mem_lat = 2; mem_silent = 1'b0; mem_stray = 1'b0; mem_rd = '0;

    // Reset state
    step(2);
    chk_eq("rst_mem_req", bus0.mem_req_o, 1'b0);
    chk_eq("rst_busy", busy0, 1'b0);
    chk_eq("rst_timeout", to0, 1'b0);
    chk_eq("rst_irvalid", bus0.instr_rvalid_o, 1'b0);
    chk_eq("rst_drvalid", bus0.data_rvalid_o, 1'b0);
    chk_eq("rst_mem_addr", bus0.mem_addr_o, 32'h0);
    rst_n = 1'b1;
    step(1);

    // Single fetch
    instr_req = 1'b1; instr_addr = 32'h100; mem_rd = 32'h0000_0013;
    step(1);
    chk_eq("f_mem_req", bus0.mem_req_o, 1'b1);
    chk_eq("f_mem_addr", bus0.mem_addr_o, 32'h100);
    chk_eq("f_mem_we", bus0.mem_we_o, 1'b0);
    chk_eq("f_mem_be", bus0.mem_be_o, 4'hF);
    chk_eq("f_mem_wdata", bus0.mem_wdata_o, 32'h0);
    chk_eq("f_busy", busy0, 1'b1);
    chk_eq("f_irvalid_early", bus0.instr_rvalid_o, 1'b0);
    step(2);
    chk_eq("f_irvalid", bus0.instr_rvalid_o, 1'b1);
    chk_eq("f_irdata", bus0.instr_rdata_o, 32'h13);
    chk_eq("f_drvalid", bus0.data_rvalid_o, 1'b0);
    chk_eq("f_timeout", to0, 1'b0);
    step(1);
    chk_eq("f_irvalid_pulse", bus0.instr_rvalid_o, 1'b0);
    chk_eq("f_mem_req_drop", bus0.mem_req_o, 1'b0);
    instr_req = 1'b0;
    step(1);

    // Simultaneous requests: data store first, instr after one bubble
    instr_req = 1'b1; instr_addr = 32'h200;
    data_req = 1'b1; data_we = 1'b1; data_addr = 32'h1000;
    data_wdata = 32'hA5A5_A5A5; data_be = 4'hF; mem_rd = 32'h0000_0077;
    step(1);
    chk_eq("t_addr", bus0.mem_addr_o, 32'h1000);
    chk_eq("t_we", bus0.mem_we_o, 1'b1);
    chk_eq("t_wdata", bus0.mem_wdata_o, 32'hA5A5_A5A5);
    chk_eq("t_be", bus0.mem_be_o, 4'hF);
    chk_eq("t_rr_addr", bus1.mem_addr_o, 32'h1000);
    step(2);
    chk_eq("t_drvalid", bus0.data_rvalid_o, 1'b1);
    chk_eq("t_irvalid", bus0.instr_rvalid_o, 1'b0);
    step(1);
    chk_eq("t_bubble_busy", busy0, 1'b0);
    chk_eq("t_bubble_req", bus0.mem_req_o, 1'b0);
    data_req = 1'b0;
    step(1);
    chk_eq("t2_req", bus0.mem_req_o, 1'b1);
    chk_eq("t2_addr", bus0.mem_addr_o, 32'h200);
    chk_eq("t2_we", bus0.mem_we_o, 1'b0);
    chk_eq("t2_wdata", bus0.mem_wdata_o, 32'h0);
    step(2);
    chk_eq("t2_irvalid", bus0.instr_rvalid_o, 1'b1);
    chk_eq("t2_irdata", bus0.instr_rdata_o, 32'h77);
    step(1);
    instr_req = 1'b0;
    step(1);

    // Continuous ties: fixed priority always data, round-robin alternates D,I,...
    instr_addr = 32'h300; data_addr = 32'h2000; data_we = 1'b0;
    data_wdata = '0; data_be = 4'hF; mem_rd = 32'h1111_2222;
    instr_req = 1'b1; data_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk_eq($sformatf("fp_grant%0d", i), bus0.mem_addr_o, 32'h2000);
      chk_eq($sformatf("rr_grant%0d", i), bus1.mem_addr_o, (i % 2 == 0) ? 32'h2000 : 32'h300);
      chk_eq($sformatf("rr_req%0d", i), bus1.mem_req_o, 1'b1);
      step(2);
      chk_eq($sformatf("fp_drv%0d", i), bus0.data_rvalid_o, 1'b1);
      chk_eq($sformatf("rr_drv%0d", i), bus1.data_rvalid_o, (i % 2 == 0) ? 1'b1 : 1'b0);
      chk_eq($sformatf("rr_irv%0d", i), bus1.instr_rvalid_o, (i % 2 == 1) ? 1'b1 : 1'b0);
      step(1);
      chk_eq($sformatf("fp_idle%0d", i), busy0, 1'b0);
      chk_eq($sformatf("rr_idle%0d", i), busy1, 1'b0);
    end
    data_req = 1'b0;
    step(1);
    chk_eq("fp_instr_late_addr", bus0.mem_addr_o, 32'h300);
    step(2);
    chk_eq("fp_instr_late_rv", bus0.instr_rvalid_o, 1'b1);
    step(1);
    instr_req = 1'b0;
    step(1);

    // Watchdog: memory silent on a data load
    mem_silent = 1'b1;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h3000;
    step(1);
    chk_eq("wd_req", bus0.mem_req_o, 1'b1);
    step(2);
    chk_eq("wd_early_rv", bus0.data_rvalid_o, 1'b0);
    chk_eq("wd_early_to", to0, 1'b0);
    step(1);
    chk_eq("wd_rvalid", bus0.data_rvalid_o, 1'b1);
    chk_eq("wd_rdata", bus0.data_rdata_o, 32'hDEAD_BEEF);
    chk_eq("wd_pulse", to0, 1'b1);
    chk_eq("wd_req_hold", bus0.mem_req_o, 1'b1);
    chk_eq("wd_irvalid", bus0.instr_rvalid_o, 1'b0);
    chk_eq("wd_rr_pulse", to1, 1'b1);
    step(1);
    chk_eq("wd_req_drop", bus0.mem_req_o, 1'b0);
    chk_eq("wd_pulse_end", to0, 1'b0);
    chk_eq("wd_busy", busy0, 1'b0);
    data_req = 1'b0;
    mem_stray = 1'b1;
    #1;
    chk_eq("stray_drv", bus0.data_rvalid_o, 1'b0);
    chk_eq("stray_irv", bus0.instr_rvalid_o, 1'b0);
    step(1);
    mem_stray = 1'b0;
    chk_eq("stray_busy", busy0, 1'b0);
    chk_eq("stray_req", bus0.mem_req_o, 1'b0);
    mem_silent = 1'b0;
    step(1);

    // Reset in the middle of a data transaction
    mem_silent = 1'b1;
    data_req = 1'b1; data_we = 1'b1; data_addr = 32'h4000;
    data_wdata = 32'h1234_5678; data_be = 4'hF;
    step(2);
    chk_eq("rb_busy", busy0, 1'b1);
    chk_eq("rb_req", bus0.mem_req_o, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_eq("ra_req", bus0.mem_req_o, 1'b0);
    chk_eq("ra_busy", busy0, 1'b0);
    data_req = 1'b0;
    mem_silent = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    instr_req = 1'b1; instr_addr = 32'h500; mem_rd = 32'hCAFE_0001;
    step(1);
    chk_eq("pr_req", bus0.mem_req_o, 1'b1);
    chk_eq("pr_addr", bus0.mem_addr_o, 32'h500);
    chk_eq("pr_we", bus0.mem_we_o, 1'b0);
    step(2);
    chk_eq("pr_irvalid", bus0.instr_rvalid_o, 1'b1);
    chk_eq("pr_irdata", bus0.instr_rdata_o, 32'hCAFE_0001);
    chk_eq("pr_drvalid", bus0.data_rvalid_o, 1'b0);
    step(1);
    instr_req = 1'b0;
    step(1);

    // Byte store held stable until the memory answers
    data_req = 1'b1; data_we = 1'b1; data_be = 4'b0100;
    data_addr = 32'h1002; data_wdata = 32'h00AB_0000; mem_rd = '0;
    step(1);
    chk_eq("bs_be", bus0.mem_be_o, 4'b0100);
    chk_eq("bs_we", bus0.mem_we_o, 1'b1);
    chk_eq("bs_addr", bus0.mem_addr_o, 32'h1002);
    chk_eq("bs_wdata", bus0.mem_wdata_o, 32'h00AB_0000);
    step(2);
    chk_eq("bs_be_hold", bus0.mem_be_o, 4'b0100);
    chk_eq("bs_we_hold", bus0.mem_we_o, 1'b1);
    chk_eq("bs_rvalid", bus0.data_rvalid_o, 1'b1);
    step(1);
    chk_eq("bs_req_drop", bus0.mem_req_o, 1'b0);
    data_req = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guard against a stuck simulation
  initial begin
    #200000;
    $display("FAIL global_timeout: sim time %0t exceeded limit", $time);
    $fatal(1, "bench did not finish");
  end
endmodule
